// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the legality rule for a request.
package load_store_unit_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Size 11 is never legal; halves need even, words need 4-byte alignment.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ill;
    case (size)
      SIZE_B:  ill = 1'b0;
      SIZE_H:  ill = addr_lo[0];
      SIZE_W:  ill = (addr_lo != 2'b00);
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response and data-memory bus signals of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit_lane_extend.sv
// Load lane selection from a memory word, followed by sign or zero extension.
module lane_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_B:  ext = {{24{sgn & lane_b[7]}}, lane_b};
      SIZE_H:  ext = {{16{sgn & lane_h[15]}}, lane_h};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access unit: one transaction in flight, bus wait states with a
// timeout, store lane encoding and load extension.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input logic             clk,
  input logic             reset,
  load_store_unit_if.slave lsu
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;

  logic [3:0]      st_be;
  logic [31:0]     st_wdata;
  logic [31:0]     load_ext;

  lane_extend u_lane_extend (
    .rdata   (lsu.mem_rdata),
    .addr_lo (addr_lo_q),
    .size    (size_q),
    .sgn     (sgn_q),
    .ext     (load_ext)
  );

  // Store narrowing; loads always read the full word.
  always_comb begin
    case (lsu.req_size)
      SIZE_B: begin
        st_be    = 4'b0001 << lsu.req_addr[1:0];
        st_wdata = {4{lsu.req_wdata[7:0]}};
      end
      SIZE_H: begin
        st_be    = lsu.req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{lsu.req_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = lsu.req_wdata;
      end
    endcase
    if (!lsu.req_we) begin
      st_be = 4'b1111;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    addr_lo_d    = addr_lo_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (lsu.req_valid) begin
          size_d    = lsu.req_size;
          sgn_d     = lsu.req_signed;
          addr_lo_d = lsu.req_addr[1:0];
          if (is_illegal(lsu.req_size, lsu.req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = ST_BUS;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = lsu.req_we;
            mem_addr_d  = {lsu.req_addr[31:2], 2'b00};
            mem_be_d    = st_be;
            mem_wdata_d = st_wdata;
          end
        end
      end
      ST_BUS: begin
        if (lsu.mem_ack) begin
          state_d      = ST_RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_we_q ? '0 : load_ext;
        end else if (cnt_q >= CntW'(TIMEOUT - 1)) begin
          // Last allowed BUS cycle passed without an ack.
          state_d      = ST_RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else if (cnt_q != CntW'(TIMEOUT)) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      size_q       <= '0;
      sgn_q        <= 1'b0;
      addr_lo_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      addr_lo_q    <= addr_lo_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign lsu.req_ready  = (state_q == ST_IDLE);
  assign lsu.resp_valid = resp_valid_q;
  assign lsu.resp_rdata = resp_rdata_q;
  assign lsu.resp_err   = resp_err_q;
  assign lsu.mem_req    = mem_req_q;
  assign lsu.mem_we     = mem_we_q;
  assign lsu.mem_addr   = mem_addr_q;
  assign lsu.mem_be     = mem_be_q;
  assign lsu.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases plus random traffic
// against a byte-arithmetic reference model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic reset;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .lsu   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } busx_t;

  resp_t resp_q[$];
  busx_t bus_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_illegal(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == SIZE_H && addr % 2 != 0) || (size == SIZE_W && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] addr, input logic [31:0] rdata);
    longint v;
    if (size == SIZE_W) return rdata;
    if (size == SIZE_B) begin
      v = (rdata >> (8 * (addr % 4))) & 32'hFF;
      if (sgn && v >= 128) v -= 256;
    end else begin
      v = (rdata >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
      if (sgn && v >= 32768) v -= 65536;
    end
    return v[31:0];
  endfunction

  function automatic busx_t model_bus(input logic we, input logic [1:0] size,
                                      input logic [31:0] addr, input logic [31:0] wdata);
    busx_t b;
    b.we   = we;
    b.addr = addr - (addr % 4);
    b.be   = 4'hF;
    b.wdata = wdata;
    if (we && size == SIZE_B) begin
      b.be    = 4'(1 << (addr % 4));
      b.wdata = {24'b0, wdata[7:0]} * 32'h01010101;
    end else if (we && size == SIZE_H) begin
      b.be    = (addr % 4 >= 2) ? 4'hC : 4'h3;
      b.wdata = {16'b0, wdata[15:0]} * 32'h00010001;
    end
    return b;
  endfunction

  // Monitor: response scoreboard plus bus request checks.
  initial begin
    resp_t r;
    busx_t cur;
    logic  prev_req;
    prev_req = 1'b0;
    cur = '{we: 1'b0, addr: '0, be: '0, wdata: '0};
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
      end else begin
        if (bus.resp_valid) begin
          if (resp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response at %0t", $time);
          end else begin
            r = resp_q.pop_front();
            check("resp_err", {31'b0, bus.resp_err}, {31'b0, r.err});
            check("resp_rdata", bus.resp_rdata, r.rdata);
          end
        end else begin
          check("quiet_rdata", bus.resp_rdata, 32'h0);
          check("quiet_err", {31'b0, bus.resp_err}, 32'h0);
        end
        if (bus.mem_req && !prev_req) begin
          if (bus_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_mem_req: got mem_req=1 expected 0 at %0t", $time);
          end else begin
            cur = bus_q.pop_front();
            check("mem_we", {31'b0, bus.mem_we}, {31'b0, cur.we});
            check("mem_addr", bus.mem_addr, cur.addr);
            check("mem_be", {28'b0, bus.mem_be}, {28'b0, cur.be});
            if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
          end
        end else if (bus.mem_req) begin
          check("mem_addr_stable", bus.mem_addr, cur.addr);
          check("mem_be_stable", {28'b0, bus.mem_be}, {28'b0, cur.be});
        end
        prev_req = bus.mem_req;
      end
    end
  end

  // ack_k: cycle after accept in which mem_ack is driven (0 = never).
  task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack_k, input int gap);
    bit    ill;
    bit    ok;
    int    n;
    int    req_cycles;
    resp_t r;
    repeat (gap) begin
      @(negedge clk);
      bus.mem_ack   = 1'($urandom);
      bus.mem_rdata = $urandom;
    end
    @(negedge clk);
    check("req_ready", {31'b0, bus.req_ready}, 32'h1);
    ill     = model_illegal(size, addr);
    ok      = !ill && ack_k >= 1 && ack_k <= int'(TO);
    r.err   = !ok;
    r.rdata = (!ok || we) ? 32'h0 : model_load(size, sgn, addr, rdata);
    resp_q.push_back(r);
    if (!ill) bus_q.push_back(model_bus(we, size, addr, wdata));
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.mem_ack    = 1'($urandom);
    n = 0;
    req_cycles = 0;
    while (1) begin
      @(negedge clk);
      n++;
      // Requests while busy must be ignored.
      bus.req_we     = 1'($urandom);
      bus.req_size   = 2'($urandom);
      bus.req_signed = 1'($urandom);
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
      if (bus.mem_req) req_cycles++;
      bus.mem_ack   = (n == ack_k);
      bus.mem_rdata = (n == ack_k) ? rdata : $urandom;
      if (bus.resp_valid || n > 40) break;
    end
    bus.req_valid = 1'b0;
    check("resp_latency", n, ill ? 1 : (ok ? ack_k + 1 : int'(TO) + 1));
    check("mem_req_cycles", req_cycles, ill ? 0 : (ok ? ack_k : int'(TO)));
  endtask

  task automatic reset_mid_bus();
    @(negedge clk);
    check("req_ready_pre", {31'b0, bus.req_ready}, 32'h1);
    bus_q.push_back(model_bus(1'b0, SIZE_W, 32'h3000, 32'h0));
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_size   = SIZE_W;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h3000;
    bus.mem_ack    = 1'b0;
    repeat (3) @(negedge clk);
    bus.req_valid = 1'b0;
    check("mem_req_before_reset", {31'b0, bus.mem_req}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("mem_req_in_reset", {31'b0, bus.mem_req}, 32'h0);
    check("resp_valid_in_reset", {31'b0, bus.resp_valid}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("req_ready_after_reset", {31'b0, bus.req_ready}, 32'h1);
    check("bus_q_drained", bus_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sz;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    #12;
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
    check("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_mem_be", {28'b0, bus.mem_be}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Loads: byte/half lanes with sign and zero extension.
    run_txn(1'b0, SIZE_B, 1'b1, 32'h1003, 32'h0, 32'h80123456, 1, 0);
    run_txn(1'b0, SIZE_B, 1'b0, 32'h1003, 32'h0, 32'h80123456, 1, 0);
    run_txn(1'b0, SIZE_H, 1'b1, 32'h2002, 32'h0, 32'h80017FFF, 2, 1);
    run_txn(1'b0, SIZE_H, 1'b0, 32'h2002, 32'h0, 32'h80017FFF, 1, 0);
    run_txn(1'b0, SIZE_H, 1'b1, 32'h2000, 32'h0, 32'h80017FFF, 3, 0);
    // Store byte lane.
    run_txn(1'b1, SIZE_B, 1'b0, 32'h12, 32'h000000AB, 32'h55555555, 1, 0);
    // Illegal requests never reach the bus.
    run_txn(1'b0, SIZE_W, 1'b0, 32'h4002, 32'h0, 32'h0, 1, 0);
    run_txn(1'b0, 2'b11, 1'b0, 32'h4000, 32'h0, 32'h0, 0, 0);
    run_txn(1'b1, SIZE_H, 1'b0, 32'h4001, 32'h1234, 32'h0, 0, 0);
    // Timeout boundary.
    run_txn(1'b0, SIZE_W, 1'b0, 32'h5000, 32'h0, 32'hDEADBEEF, 0, 0);
    run_txn(1'b0, SIZE_W, 1'b0, 32'h5000, 32'h0, 32'hDEADBEEF, TO + 1, 0);
    run_txn(1'b0, SIZE_W, 1'b0, 32'h5000, 32'h0, 32'hDEADBEEF, TO, 0);
    // Reset during BUS, then a normal store word.
    reset_mid_bus();
    run_txn(1'b1, SIZE_W, 1'b0, 32'h3004, 32'hCAFEF00D, 32'h0, 2, 0);

    for (int i = 0; i < 150; i++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_txn(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom,
              $urandom_range(0, TO + 2), $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    check("resp_q_empty", resp_q.size(), 0);
    check("bus_q_empty", bus_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
